// File: rtl/cv32e40p_apu_resp_buffer.sv
// APU response buffer: credit-metered request issue plus a small result FIFO.
// The same-cycle result bypass is compiled in only when CV32E40P_APU_RESP_BYPASS_EN is defined.
module cv32e40p_apu_resp_buffer #(
    parameter int DEPTH       = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int FLAGS_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   core_req_i,
    output logic                   core_gnt_o,
    output logic                   fpu_req_o,
    input  logic                   fpu_gnt_i,
    input  logic                   fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]  fpu_rdata_i,
    input  logic [FLAGS_WIDTH-1:0] fpu_rflags_i,
    output logic                   core_rvalid_o,
    output logic [DATA_WIDTH-1:0]  core_rdata_o,
    output logic [FLAGS_WIDTH-1:0] core_rflags_o,
    input  logic                   core_rready_i,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = DATA_WIDTH + FLAGS_WIDTH;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_occ;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          r_err;
    logic [EW-1:0] r_mem [DEPTH];

    logic          w_credit_ok;
    logic          w_issue;
    logic          w_empty;
    logic          w_full;
    logic          w_fifo_pop;
    logic          w_bypass;
    logic          w_pop;
    logic          w_push;
    logic          w_err_set;
    logic [EW-1:0] w_head;
    logic [EW-1:0] w_out;

    // Credits come only from the registered count, so core_rready_i never reaches core_gnt_o.
    assign w_credit_ok = (r_cnt < DEPTH_C);
    assign fpu_req_o   = core_req_i & w_credit_ok;
    assign core_gnt_o  = fpu_gnt_i & w_credit_ok;
    assign w_issue     = fpu_req_o & fpu_gnt_i;

    assign w_empty    = (r_occ == '0);
    assign w_full     = (r_occ == DEPTH_C);
    assign w_fifo_pop = ~w_empty & core_rready_i;
    assign w_head     = r_mem[r_rptr];

`ifdef CV32E40P_APU_RESP_BYPASS_EN
    assign w_bypass = w_empty & fpu_rvalid_i & core_rready_i;
    assign w_out    = w_empty ? {fpu_rdata_i, fpu_rflags_i} : w_head;
`else
    assign w_bypass = 1'b0;
    assign w_out    = w_head;
`endif

    assign core_rvalid_o = ~w_empty | w_bypass;
    assign core_rdata_o  = w_out[EW-1:FLAGS_WIDTH];
    assign core_rflags_o = w_out[FLAGS_WIDTH-1:0];
    assign w_pop         = core_rvalid_o & core_rready_i;

    // A full FIFO still accepts a result when the head leaves in the same cycle.
    assign w_push    = fpu_rvalid_i & ~w_bypass & (~w_full | w_fifo_pop);
    assign w_err_set = fpu_rvalid_i & ((w_full & ~w_fifo_pop) | (r_cnt == r_occ));

    assign busy_o = (r_cnt != '0);
    assign err_o  = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_occ  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_issue && !w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_issue && w_pop) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_push && !w_fifo_pop) begin
                r_occ <= r_occ + CW'(1);
            end else if (!w_push && w_fifo_pop) begin
                r_occ <= r_occ - CW'(1);
            end

            if (w_push) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
            end
            if (w_fifo_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Result storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {fpu_rdata_i, fpu_rflags_i};
        end
    end

endmodule
